res_line_cache_ctrl: RTL

- Sequences the resolution-text ROM, which is indexed by video mode id and 4-bit row address, returns one line per row and has 1-cycle registered latency.
- On every video mode change it bulk-loads all text rows for the new mode into a ping-pong line cache.
- It swaps banks only at a frame boundary, so the OSD renderer never shows mixed rows from two modes.
- The renderer reads the cache through a fixed-latency port and never touches the ROM directly.

---
 rtl/res_line_cache_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/res_line_cache_ctrl.sv
// res_line_cache_ctrl: loads every text row of the current video mode from the
// resolution ROM into the shadow bank of a ping-pong line cache. The banks swap
// only on a frame_start pulse, so the OSD renderer never mixes rows of two modes.
module res_line_cache_ctrl #(
  parameter int MODE_W = 5,
  parameter int ROWS   = 16,
  parameter int ADDR_W = 4,
  parameter int LINE_W = 160
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [MODE_W-1:0] mode_id,
  input  logic              frame_start,
  output logic [MODE_W-1:0] rom_mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [LINE_W-1:0] rom_q,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [LINE_W-1:0] rd_data,
  output logic              cache_valid,
  output logic              busy,
  output logic [MODE_W-1:0] active_mode
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_PENDING = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] ROWS_C = (ADDR_W+1)'(ROWS);
  localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(ROWS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [MODE_W-1:0]   fetch_mode_q, fetch_mode_d;
  logic                need_load_q, need_load_d;
  logic                bank_q, bank_d;
  logic [MODE_W-1:0]   active_mode_q, active_mode_d;
  logic                cache_valid_q, cache_valid_d;
  logic [MODE_W-1:0]   rom_mode_q, rom_mode_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0]   addr_d_q, addr_d_d;
  logic                busy_q, busy_d;
  logic [LINE_W-1:0]   rd_data_q, rd_data_d;
  logic                abort_s;
  logic                rd_in_range_s;

  // Two banks of cached lines; bank_q selects the read side, ~bank_q is written.
  logic [LINE_W-1:0]   mem_q [0:1][0:ROWS-1];

  // Next-state logic: load sequencing, abort on mode change, frame-aligned swap.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fetch_mode_d  = fetch_mode_q;
    need_load_d   = need_load_q;
    bank_d        = bank_q;
    active_mode_d = active_mode_q;
    cache_valid_d = cache_valid_q;
    rom_mode_d    = rom_mode_q;
    rom_addr_d    = rom_addr_q;
    wr_vld_d      = 1'b0;
    addr_d_d      = addr_d_q;
    // A mode change while a load is outstanding restarts it; it also beats a
    // same-cycle frame_start so a stale bank is never swapped in.
    abort_s       = (state_q != ST_IDLE) && (mode_id != fetch_mode_q);

    case (state_q)
      ST_IDLE: begin
        if (need_load_q || (mode_id != active_mode_q)) begin
          need_load_d  = 1'b0;
          fetch_mode_d = mode_id;
          rom_mode_d   = mode_id;
          cnt_d        = {(ADDR_W+1){1'b0}};
          rom_addr_d   = {ADDR_W{1'b0}};
          state_d      = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // rom_addr_q equals cnt_q here; its data lands one cycle later.
        wr_vld_d = 1'b1;
        addr_d_d = cnt_q[ADDR_W-1:0];
        cnt_d    = cnt_q + (ADDR_W+1)'(1);
        if (cnt_q == LAST_C) begin
          state_d = ST_DRAIN;
        end else begin
          rom_addr_d = cnt_d[ADDR_W-1:0];
        end
      end
      ST_DRAIN: begin
        state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_start && !abort_s) begin
          bank_d        = ~bank_q;
          active_mode_d = fetch_mode_q;
          cache_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_PENDING;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_s) begin
      fetch_mode_d = mode_id;
      rom_mode_d   = mode_id;
      cnt_d        = {(ADDR_W+1){1'b0}};
      rom_addr_d   = {ADDR_W{1'b0}};
      wr_vld_d     = 1'b0;
      state_d      = ST_FETCH;
    end else begin
      fetch_mode_d = fetch_mode_d;
    end

    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  // Read port: one-cycle registered lookup in the active bank.
  always_comb begin
    rd_in_range_s = ({1'b0, rd_addr} < ROWS_C);
    if (cache_valid_q && rd_in_range_s) begin
      rd_data_d = mem_q[bank_q][rd_addr];
    end else begin
      rd_data_d = {LINE_W{1'b0}};
    end
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {(ADDR_W+1){1'b0}};
      fetch_mode_q  <= {MODE_W{1'b0}};
      need_load_q   <= 1'b1;
      bank_q        <= 1'b0;
      active_mode_q <= {MODE_W{1'b0}};
      cache_valid_q <= 1'b0;
      rom_mode_q    <= {MODE_W{1'b0}};
      rom_addr_q    <= {ADDR_W{1'b0}};
      wr_vld_q      <= 1'b0;
      addr_d_q      <= {ADDR_W{1'b0}};
      busy_q        <= 1'b0;
      rd_data_q     <= {LINE_W{1'b0}};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_mode_q  <= fetch_mode_d;
      need_load_q   <= need_load_d;
      bank_q        <= bank_d;
      active_mode_q <= active_mode_d;
      cache_valid_q <= cache_valid_d;
      rom_mode_q    <= rom_mode_d;
      rom_addr_q    <= rom_addr_d;
      wr_vld_q      <= wr_vld_d;
      addr_d_q      <= addr_d_d;
      busy_q        <= busy_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Shadow-bank fill from the ROM; contents are gated by cache_valid, not reset.
  always_ff @(posedge clock) begin
    if (wr_vld_q) begin
      mem_q[~bank_q][addr_d_q] <= rom_q;
    end
  end

  assign rom_mode    = rom_mode_q;
  assign rom_addr    = rom_addr_q;
  assign rd_data     = rd_data_q;
  assign cache_valid = cache_valid_q;
  assign busy        = busy_q;
  assign active_mode = active_mode_q;

endmodule
